// File: rtl/sysbus_ctrl.sv
// rtl/sysbus_ctrl.sv - CPU-to-slave system bus controller with page decode, wait states and timeout error
// Optional memory-scan engine compiled in by defining SYSBUS_MEMTEST_EN.
module sysbus_ctrl #(
    parameter int          WIDTH    = 32,
    parameter int          NSLV     = 5,
    parameter int          SEL_LO   = 12,
    parameter logic [63:0] SLV_PAGE = 64'h0000_0000_000F_EDC0,
    parameter int          TIMEOUT  = 15,
    parameter int          MT_SLV   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_req,
    input  logic                  m_wen,
    input  logic [WIDTH-1:0]      m_addr,
    input  logic [WIDTH-1:0]      m_wdata,
    output logic [WIDTH-1:0]      m_rdata,
    output logic                  m_ready,
    output logic                  m_err,
    output logic [NSLV-1:0]       s_cs,
    output logic                  s_wen,
    output logic [WIDTH-1:0]      s_addr,
    output logic [WIDTH-1:0]      s_wdata,
    input  logic [NSLV*WIDTH-1:0] s_rdata,
    input  logic [NSLV-1:0]       s_ready,
    input  logic                  mt_en,
    output logic [WIDTH-1:0]      mt_addr
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t          r_state, w_nxt_state;
    logic [NSLV-1:0] r_s_cs, w_nxt_cs;
    logic            r_s_wen, w_nxt_wen;
    logic [WIDTH-1:0] r_s_addr, w_nxt_addr;
    logic [WIDTH-1:0] r_s_wdata, w_nxt_wdata;
    logic [WIDTH-1:0] r_m_rdata, w_nxt_rdata;
    logic            r_m_ready, w_nxt_ready;
    logic            r_m_err, w_nxt_err;
    logic [7:0]      r_wait, w_nxt_wait;
    logic [SW-1:0]   r_sel, w_nxt_sel;

    logic            w_hit;
    logic [SW-1:0]   w_sel;
    logic            w_rdy;
    logic [WIDTH-1:0] w_rdat;
    logic            w_scan_en;
    logic            w_scan_go;
    logic [WIDTH-1:0] w_mt_next;

    // Descending scan so the lowest-index matching slave is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (m_addr[SEL_LO +: 4] == SLV_PAGE[4*i +: 4]) begin
                w_hit = 1'b1;
                w_sel = SW'(i);
            end
        end
    end

    always_comb begin
        w_rdy  = 1'b0;
        w_rdat = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel == SW'(i)) begin
                w_rdy  = s_ready[i];
                w_rdat = s_rdata[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_scan_go = (r_state == ST_IDLE) && w_scan_en;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cs    = '0;
        w_nxt_wen   = 1'b0;
        w_nxt_addr  = r_s_addr;
        w_nxt_wdata = r_s_wdata;
        w_nxt_rdata = r_m_rdata;
        w_nxt_ready = 1'b0;
        w_nxt_err   = 1'b0;
        w_nxt_wait  = r_wait;
        w_nxt_sel   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_scan_go) begin
                    w_nxt_cs   = NSLV'(1) << MT_SLV;
                    w_nxt_addr = w_mt_next;
                end else if (m_req) begin
                    w_nxt_addr  = m_addr;
                    w_nxt_wdata = m_wdata;
                    w_nxt_sel   = w_sel;
                    w_nxt_wait  = '0;
                    if (w_hit) begin
                        w_nxt_cs    = NSLV'(1) << w_sel;
                        w_nxt_wen   = m_wen;
                        w_nxt_state = ST_ACCESS;
                    end else begin
                        w_nxt_rdata = '1;
                        w_nxt_ready = 1'b1;
                        w_nxt_err   = 1'b1;
                        w_nxt_state = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                w_nxt_cs   = r_s_cs;
                w_nxt_wen  = r_s_wen;
                w_nxt_wait = r_wait + 8'd1;
                if (w_rdy) begin
                    if (!r_s_wen) w_nxt_rdata = w_rdat;
                    w_nxt_cs    = '0;
                    w_nxt_wen   = 1'b0;
                    w_nxt_ready = 1'b1;
                    w_nxt_state = ST_RESP;
                end else if (r_wait == 8'(TIMEOUT)) begin
                    w_nxt_rdata = '1;
                    w_nxt_cs    = '0;
                    w_nxt_wen   = 1'b0;
                    w_nxt_ready = 1'b1;
                    w_nxt_err   = 1'b1;
                    w_nxt_state = ST_RESP;
                end
            end
            ST_RESP: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_s_cs    <= '0;
            r_s_wen   <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_m_rdata <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_wait    <= '0;
            r_sel     <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_s_cs    <= w_nxt_cs;
            r_s_wen   <= w_nxt_wen;
            r_s_addr  <= w_nxt_addr;
            r_s_wdata <= w_nxt_wdata;
            r_m_rdata <= w_nxt_rdata;
            r_m_ready <= w_nxt_ready;
            r_m_err   <= w_nxt_err;
            r_wait    <= w_nxt_wait;
            r_sel     <= w_nxt_sel;
        end
    end

`ifdef SYSBUS_MEMTEST_EN
    logic             r_scan;
    logic [WIDTH-1:0] r_mt_addr;

    // The first scan cycle presents the held address; later cycles advance it.
    assign w_scan_en = mt_en;
    assign w_mt_next = r_mt_addr + (r_scan ? WIDTH'(1) : WIDTH'(0));
    assign mt_addr   = r_mt_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan    <= 1'b0;
            r_mt_addr <= '0;
        end else begin
            r_scan <= w_scan_go;
            if (w_scan_go) r_mt_addr <= w_mt_next;
        end
    end
`else
    logic w_unused_mt;
    assign w_unused_mt = mt_en;
    assign w_scan_en   = 1'b0;
    assign w_mt_next   = '0;
    assign mt_addr     = '0;
`endif

    assign m_rdata = r_m_rdata;
    assign m_ready = r_m_ready;
    assign m_err   = r_m_err;
    assign s_cs    = r_s_cs;
    assign s_wen   = r_s_wen;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
endmodule

// File: tb/tb_sysbus_ctrl.sv
// tb/tb_sysbus_ctrl.sv - randomized self-checking bench for sysbus_ctrl against a transaction-level model
module tb_sysbus_ctrl;
    localparam int NSLV    = 5;
    localparam int TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 m_req = 1'b0;
    logic                 m_wen = 1'b0;
    logic [31:0]          m_addr = '0;
    logic [31:0]          m_wdata = '0;
    logic [31:0]          m_rdata;
    logic                 m_ready;
    logic                 m_err;
    logic [NSLV-1:0]      s_cs;
    logic                 s_wen;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic [NSLV*32-1:0]   s_rdata = '0;
    logic [NSLV-1:0]      s_ready = '0;
    logic                 mt_en = 1'b0;
    logic [31:0]          mt_addr;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          page_tab [NSLV] = '{0, 12, 13, 14, 15};
    logic [31:0] model_rdata = '0;

    sysbus_ctrl dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_cs(s_cs), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .mt_en(mt_en), .mt_addr(mt_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the controller idle; returns likewise.
    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int k);
        int              sel;
        logic [NSLV-1:0] oh;
        logic            tmo;
        sel = -1;
        for (int i = 0; i < NSLV; i++)
            if (sel < 0 && page_tab[i] == int'(addr[15:12])) sel = i;
        for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = $urandom;
        if (sel >= 0) s_rdata[32*sel +: 32] = rd;
        s_ready = '0;
        m_req = 1'b1; m_wen = wen; m_addr = addr; m_wdata = wd;
        @(posedge clk); #1;
        m_req = 1'($urandom); m_wen = 1'($urandom); m_addr = $urandom; m_wdata = $urandom;
        if (sel < 0) begin
            model_rdata = '1;
            @(negedge clk);
            chk("unmap_ready", m_ready, 1);
            chk("unmap_err", m_err, 1);
            chk("unmap_cs", s_cs, 0);
            chk("unmap_rdata", m_rdata, model_rdata);
        end else begin
            oh = NSLV'(1) << sel;
            for (int c = 0; c <= TIMEOUT; c++) begin
                @(negedge clk);
                chk("acc_cs", s_cs, oh);
                chk("acc_wen", s_wen, wen);
                chk("acc_addr", s_addr, addr);
                chk("acc_wdata", s_wdata, wd);
                chk("acc_noready", m_ready, 0);
                s_ready = (NSLV'($urandom) & ~oh) | ((c >= k) ? oh : '0);
                @(posedge clk); #1;
                if (c >= k) break;
            end
            s_ready = '0;
            tmo = (k > TIMEOUT);
            if (tmo) model_rdata = '1;
            else if (!wen) model_rdata = rd;
            @(negedge clk);
            chk("resp_ready", m_ready, 1);
            chk("resp_err", m_err, tmo);
            chk("resp_rdata", m_rdata, model_rdata);
            chk("resp_cs", s_cs, 0);
            chk("resp_wen", s_wen, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          r;
        int          k;
        int          pg;
        logic [31:0] a;
        int          pages [6] = '{0, 12, 13, 14, 15, 5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", m_rdata, 0);
        chk("rst_ready", m_ready, 0);
        chk("rst_err", m_err, 0);
        chk("rst_cs", s_cs, 0);
        chk("rst_wen", s_wen, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_mt", mt_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef SYSBUS_MEMTEST_EN
        mt_en = 1'b1; m_req = 1'b1; m_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("scan_mt", mt_addr, i);
            chk("scan_addr", s_addr, i);
            chk("scan_cs", s_cs, 1);
            chk("scan_wen", s_wen, 0);
            chk("scan_noready", m_ready, 0);
        end
        mt_en = 1'b0; m_req = 1'b0;
        @(negedge clk);
        chk("scan_off_cs", s_cs, 0);
        chk("scan_hold_mt", mt_addr, 3);
        @(posedge clk); #1;
`else
        mt_en = 1'b1;
        run_txn(1'b0, 32'h0000_E020, 32'h0, 32'h0BAD_F00D, 1);
        chk("noscan_mt", mt_addr, 0);
        mt_en = 1'b0;
`endif

        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
        run_txn(1'b1, 32'h0000_F003, 32'h0000_00A5, 32'h5555_AAAA, 0);
        run_txn(1'b0, 32'h0000_C000, 32'h0, 32'hCAFE_0001, 3);
        run_txn(1'b0, 32'h0000_D100, 32'h0, 32'h1111_2222, 200);
        run_txn(1'b0, 32'h0000_5000, 32'h0, 32'h3333_4444, 0);
        run_txn(1'b0, 32'h0000_E004, 32'h0, 32'h7777_8888, TIMEOUT);
        run_txn(1'b1, 32'h0000_C008, 32'h0000_0042, 32'h0, TIMEOUT + 1);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 6);
            pg = (r == 6) ? int'($urandom_range(0, 15)) : pages[r];
            a  = $urandom;
            a[15:12] = 4'(pg);
            r = $urandom_range(0, 9);
            k = (r < 6) ? r : (r == 6) ? TIMEOUT : (r == 7) ? TIMEOUT + 1 : 60;
            run_txn(1'($urandom), a, $urandom, $urandom, k);
        end

        m_req = 1'b0;
        s_ready = '0;
        m_req = 1'b1; m_wen = 1'b1; m_addr = 32'h0000_D040; m_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        m_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_cs", s_cs, 5'b00100);
        reset = 1'b1;
        #1;
        model_rdata = '0;
        chk("mid_rst_rdata", m_rdata, 0);
        chk("mid_rst_ready", m_ready, 0);
        chk("mid_rst_err", m_err, 0);
        chk("mid_rst_cs", s_cs, 0);
        chk("mid_rst_wen", s_wen, 0);
        chk("mid_rst_addr", s_addr, 0);
        chk("mid_rst_wdata", s_wdata, 0);
        chk("mid_rst_mt", mt_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_noready", m_ready, 0);
            chk("post_rst_cs", s_cs, 0);
        end
        @(posedge clk); #1;
        run_txn(1'b0, 32'h0000_0abc, 32'h0, 32'h600D_CAFE, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
